// File: rtl/ifid_fetch_stage_pkg.sv
// Shared IF/ID constants and helpers; decode and forwarding logic reuse the
// instruction field positions and the hard-wired zero register defined here.
package ifid_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Number of source-register fields a dependent instruction can read.
    localparam int NUM_SRC = 2;

    typedef enum logic [1:0] {
        UPD_NORMAL,
        UPD_HOLD,
        UPD_BRANCH
    } upd_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ifid_fetch_stage_hazard.sv
// Load-use hazard detector: flags when the load in EX writes a register that
// the instruction sitting in IF/ID reads as rs or rt. Purely combinational.
module load_use_hazard_unit
    import ifid_fetch_stage_pkg::*;
(
    input  logic       ifid_valid,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_write_reg,
    output logic       hazard_bubble
);

    logic [NUM_SRC-1:0][4:0] src;
    logic [NUM_SRC-1:0]      src_match;

    assign src[0] = ifid_rs;
    assign src[1] = ifid_rt;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign src_match[s] = (src[s] == idex_write_reg);
    end

    // $0 is hard-wired, so a load targeting it never produces a dependency.
    assign hazard_bubble = ifid_valid & idex_mem_read
                         & (idex_write_reg != REG_ZERO) & (|src_match);

endmodule

// File: rtl/ifid_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and load-use stall.
// Optional: define IFID_STALL_COUNT_EN to add a saturating Stall_Count output.
module ifid_fetch_stage
    import ifid_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    input  logic        Ext_Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_WriteReg,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC4,
    output logic        IFID_Valid,
    output logic        Hazard_Bubble
`ifdef IFID_STALL_COUNT_EN
    ,
    output logic [15:0] Stall_Count
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        hold;
    upd_e        upd;

    // Targets are word aligned; the low bits of the redirect are dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = &{1'b0, Branch_Target[1:0]};

    assign IMem_Addr = pc;
    assign pc_plus   = pc + STEP;

    load_use_hazard_unit u_hazard (
        .ifid_valid     (IFID_Valid),
        .ifid_rs        (IFID_Instruction[RS_MSB:RS_LSB]),
        .ifid_rt        (IFID_Instruction[RT_MSB:RT_LSB]),
        .idex_mem_read  (IDEX_MemRead),
        .idex_write_reg (IDEX_WriteReg),
        .hazard_bubble  (Hazard_Bubble)
    );

    assign hold = Hazard_Bubble | Ext_Stall;

    // A redirect squashes whatever is stalled, so it outranks hold.
    always_comb begin
        upd = UPD_NORMAL;
        if (Branch_Taken)
            upd = UPD_BRANCH;
        else if (hold)
            upd = UPD_HOLD;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc               <= RESET_PC;
            IFID_Instruction <= NOP_INSTR;
            IFID_PC4         <= 32'h0;
            IFID_Valid       <= 1'b0;
        end else begin
            case (upd)
                UPD_BRANCH: begin
                    pc               <= {Branch_Target[31:2], 2'b00};
                    IFID_Instruction <= NOP_INSTR;
                    IFID_PC4         <= 32'h0;
                    IFID_Valid       <= 1'b0;
                end
                UPD_NORMAL: begin
                    pc               <= pc_plus;
                    IFID_Instruction <= IMem_Data;
                    IFID_PC4         <= pc_plus;
                    IFID_Valid       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef IFID_STALL_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            Stall_Count <= 16'h0;
        else if (upd == UPD_HOLD)
            Stall_Count <= sat_inc16(Stall_Count);
    end
`endif

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Self-checking bench for ifid_fetch_stage: directed plan items plus random
// traffic, all checked against a behavioural model through a scoreboard queue.
module tb_ifid_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IMem_Addr;
    logic [31:0] IMem_Data;
    logic        Ext_Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_WriteReg;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC4;
    logic        IFID_Valid;
    logic        Hazard_Bubble;
`ifdef IFID_STALL_COUNT_EN
    logic [15:0] Stall_Count;
`endif

    ifid_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IMem_Addr        (IMem_Addr),
        .IMem_Data        (IMem_Data),
        .Ext_Stall        (Ext_Stall),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_WriteReg    (IDEX_WriteReg),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC4         (IFID_PC4),
        .IFID_Valid       (IFID_Valid),
        .Hazard_Bubble    (Hazard_Bubble)
`ifdef IFID_STALL_COUNT_EN
        ,
        .Stall_Count      (Stall_Count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        bubble;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference state: what the fetch stage should hold, in architectural terms.
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_bubble(input logic mr, input logic [4:0] wr);
        logic [4:0] rs, rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        return m_valid && mr && (wr != 5'd0) && (wr == rs || wr == rt);
    endfunction

    // One clock: drive inputs just after the edge, queue the expected view of
    // this cycle, then advance the model to what the next edge should produce.
    task automatic cyc(input logic rst, input logic es, input logic bt,
                       input logic [31:0] btgt, input logic mr,
                       input logic [4:0] wr, input logic [31:0] data);
        exp_t e;
        logic stall;
        @(posedge Clk);
        #1;
        Reset = rst; Ext_Stall = es; Branch_Taken = bt; Branch_Target = btgt;
        IDEX_MemRead = mr; IDEX_WriteReg = wr; IMem_Data = data;
        if (m_known) begin
            e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
            e.bubble = model_bubble(mr, wr); e.cnt = m_cnt;
            q.push_back(e);
        end
        stall = model_bubble(mr, wr) || es;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
            m_known = 1'b1;
        end else if (bt) begin
            m_pc = btgt & 32'hFFFF_FFFC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (stall) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_instr = data; m_pc4 = m_pc + 32'd4; m_pc = m_pc4; m_valid = 1'b1;
        end
    endtask

    task automatic run(input logic [31:0] data);
        cyc(0, 0, 0, 32'h0, 0, 5'd0, data);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr",  IMem_Addr,        e.addr);
                chk("ifid_instr", IFID_Instruction, e.instr);
                chk("ifid_pc4",   IFID_PC4,         e.pc4);
                chk("ifid_valid", {31'h0, IFID_Valid},    {31'h0, e.valid});
                chk("bubble",     {31'h0, Hazard_Bubble}, {31'h0, e.bubble});
`ifdef IFID_STALL_COUNT_EN
                chk("stall_cnt",  {16'h0, Stall_Count},   {16'h0, e.cnt});
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] LW_DEP = 32'h0128_5020;

    initial begin : stim
        logic [31:0] pc_h;
        logic [4:0]  rs, rt;
        Reset = 1; Ext_Stall = 0; Branch_Taken = 0; Branch_Target = 0;
        IDEX_MemRead = 0; IDEX_WriteReg = 0; IMem_Data = 0;

        // Reset then free-run
        cyc(1, 0, 0, 0, 0, 0, 32'h2010_0001);
        run(32'h2010_0001);
        #1 chk("rst_addr", IMem_Addr, 32'h0);
        chk("rst_valid", {31'h0, IFID_Valid}, 32'h0);
        run(32'h2010_0001);
        #1 chk("run_addr4", IMem_Addr, 32'h4);
        chk("run_valid", {31'h0, IFID_Valid}, 32'h1);
        chk("run_pc4", IFID_PC4, 32'h4);
        run(LW_DEP);
        #1 chk("run_addr8", IMem_Addr, 32'h8);

        // Load-use: IFID holds LW_DEP, load into $9 in EX
        cyc(0, 0, 0, 0, 1, 5'd9, LW_DEP);
        #1 chk("lu_bubble", {31'h0, Hazard_Bubble}, 32'h1);
        pc_h = IMem_Addr;
        run(LW_DEP);
        #1 chk("lu_pc_held", IMem_Addr, pc_h);
        chk("lu_instr_held", IFID_Instruction, LW_DEP);
        chk("lu_bubble_drop", {31'h0, Hazard_Bubble}, 32'h0);
        run(LW_DEP);
        #1 chk("lu_pc_adv", IMem_Addr, pc_h + 32'd4);

        // Load into $0 never stalls
        cyc(0, 0, 0, 0, 1, 5'd0, LW_DEP);
        #1 chk("r0_no_bubble", {31'h0, Hazard_Bubble}, 32'h0);
        pc_h = IMem_Addr;
        run(LW_DEP);
        #1 chk("r0_pc_adv", IMem_Addr, pc_h + 32'd4);

        // Branch beats concurrent hazard and external stall
        cyc(0, 1, 1, 32'h0000_0103, 1, 5'd9, LW_DEP);
        #1 chk("br_bubble", {31'h0, Hazard_Bubble}, 32'h1);
        run(LW_DEP);
        #1 chk("br_pc", IMem_Addr, 32'h0000_0100);
        chk("br_valid", {31'h0, IFID_Valid}, 32'h0);
        chk("br_instr", IFID_Instruction, 32'h0);

        // PC wrap
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, LW_DEP);
        run(LW_DEP);
        #1 chk("wrap_pre", IMem_Addr, 32'hFFFF_FFFC);
        run(LW_DEP);
        #1 chk("wrap_pc", IMem_Addr, 32'h0);
        chk("wrap_pc4", IFID_PC4, 32'h0);

        // Reset in the middle of a 3-cycle external stall
        cyc(0, 1, 0, 0, 0, 0, LW_DEP);
        cyc(0, 1, 0, 0, 0, 0, LW_DEP);
        cyc(1, 1, 0, 0, 0, 0, LW_DEP);
        run(LW_DEP);
        #1 chk("rst_stall_pc", IMem_Addr, 32'h0);
        chk("rst_stall_valid", {31'h0, IFID_Valid}, 32'h0);
`ifdef IFID_STALL_COUNT_EN
        chk("cnt_after_rst", {16'h0, Stall_Count}, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, LW_DEP);
        cyc(0, 1, 0, 0, 0, 0, LW_DEP);
        cyc(0, 1, 0, 0, 0, 0, LW_DEP);
        run(LW_DEP);
        #1 chk("cnt_three", {16'h0, Stall_Count}, 32'h3);
`endif

        // Random traffic with a small register pool so hazards are common
        for (int i = 0; i < 400; i++) begin
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0),
                $urandom,
                1'($urandom),
                5'($urandom_range(0, 3)),
                {6'($urandom), rs, rt, 16'($urandom)});
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_fetch_stage.md
Name: ifid_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID/EX buffer.
- Owns the PC and drives the instruction-memory address; memory read is combinational.
- Registers instruction, PC+4 and a valid bit for the decode stage.
- Performs load-use hazard detection against the ID/EX stage; stalls PC and IF/ID; raises a bubble request so decode zeroes the controls it feeds into ID/EX.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- PC_STEP, 4: byte increment per sequential fetch.

Ports:
- Clk, input, 1: rising-edge clock.
- Reset, input, 1: synchronous, active-high reset.
- IMem_Addr, output, 32: fetch address; equals the PC register.
- IMem_Data, input, 32: instruction word at IMem_Addr, same cycle.
- Ext_Stall, input, 1: external hold, e.g. a memory wait.
- Branch_Taken, input, 1: redirect request resolved in EX.
- Branch_Target, input, 32: redirect address.
- IDEX_MemRead, input, 1: the instruction in EX is a load.
- IDEX_WriteReg, input, 5: destination register of the instruction in EX.
- IFID_Instruction, output, 32: registered instruction to decode.
- IFID_PC4, output, 32: registered PC+PC_STEP of that instruction.
- IFID_Valid, output, 1: 1 when IFID_Instruction is a real instruction.
- Hazard_Bubble, output, 1: combinational; decode must insert a zero-control bubble into ID/EX this cycle.

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - IFID_Instruction = 32'h0 (NOP).
  - IFID_PC4 = 0, IFID_Valid = 0.
  - Hazard_Bubble evaluates to 0 because IFID_Valid = 0.
- Reset wins over every other input in the same cycle. Asserting reset mid-stall or mid-redirect discards all pending state.
- Hazard detection (combinational):
  - Hazard_Bubble = IFID_Valid & IDEX_MemRead & (IDEX_WriteReg != 0) & (IDEX_WriteReg == IFID_Instruction[25:21] | IDEX_WriteReg == IFID_Instruction[20:16]).
  - Register $0 never triggers a hazard.
- Hold = Hazard_Bubble | Ext_Stall.
- Priority per rising edge, highest first: Reset > Branch_Taken > Hold > normal.
- Branch_Taken:
  - PC <= {Branch_Target[31:2], 2'b00}.
  - IFID_Instruction <= 0, IFID_Valid <= 0, IFID_PC4 <= 0.
  - Overrides a concurrent Hold; the stalled instruction is squashed.
- Hold, without a branch: PC and all IFID_* registers keep their values.
- Normal:
  - PC <= PC + PC_STEP, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - IFID_Instruction <= IMem_Data, IFID_PC4 <= PC + PC_STEP, IFID_Valid <= 1.
- Latency: an instruction fetched at edge N is visible on IFID_* after edge N. A load-use hazard costs exactly one bubble cycle: after the stall edge the load has left EX, so Hazard_Bubble drops.
- Ext_Stall may persist for any number of cycles; there is no timeout.
- Hazard_Bubble stays asserted during Ext_Stall only while its terms remain true.
- Hazard_Bubble also asserts in a cycle where Branch_Taken is high; the downstream bubble is harmless because the branch flushes the stage.

Optional Feature:
- Macro: IFID_STALL_COUNT_EN.
- Defined:
  - Adds output Stall_Count (16 bits), reset to 0.
  - Increments on every edge where Hold = 1 and Branch_Taken = 0 and Reset = 0.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0.
  - Field constants RS_MSB/RS_LSB = 25/21 and RT_MSB/RT_LSB = 20/16.
  - The REG_ZERO = 5'd0 constant.
  - Reused by decode and forwarding logic.
- Natural sub-module: load_use_hazard_unit. It is purely combinational and produces Hazard_Bubble from the IF/ID instruction fields and the IDEX_* inputs. PC and register logic stay in the top.

Test Plan:
- Reset then free-run with IMem_Data = 32'h2010_0001 → IMem_Addr sequence 0, 4, 8; one edge after leaving reset, IFID_Valid = 1 and IFID_PC4 = 4.
- IFID holds lw-dependent 32'h0128_5020 (rs = 9, rt = 8), IDEX_MemRead = 1, IDEX_WriteReg = 9 → Hazard_Bubble = 1; PC and IFID unchanged for one edge; next cycle with IDEX_MemRead = 0, Hazard_Bubble = 0 and PC advances.
- Same instruction, IDEX_WriteReg = 0, IDEX_MemRead = 1 → no bubble; PC advances.
- Branch_Taken = 1, Branch_Target = 32'h0000_0103, with a concurrent hazard and Ext_Stall = 1 → PC = 32'h0000_0100, IFID_Valid = 0, IFID_Instruction = 0.
- PC = 32'hFFFF_FFFC under normal flow → next PC = 0; IFID_PC4 = 0.
- Reset asserted during a 3-cycle Ext_Stall → PC = RESET_PC, IFID_Valid = 0. With IFID_STALL_COUNT_EN defined, Stall_Count = 0 after reset and reads 3 after a later 3-cycle stall.
